// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared FSM encoding and default NOP word for program_memory
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - byte-wide program store: one synchronous write port, four combinational reads
module prog_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    input  logic [ADDR_W-1:0] raddr3_i,
    output logic [7:0]        rdata0_o,
    output logic [7:0]        rdata1_o,
    output logic [7:0]        rdata2_o,
    output logic [7:0]        rdata3_o
);

    // No reset: program contents must survive a reset of the controller.
    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/program_memory.sv
// rtl/program_memory.sv - loadable program memory with 32-bit instruction fetch; PROG_CHECKSUM_EN adds a load checksum
module program_memory
    import prog_mem_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_done,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       opbus,
    output logic              op_valid,
    output logic [ADDR_W:0]   prog_len,
    output logic              overflow,
    output logic [1:0]        state
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       opbus_q, opbus_d;
    logic              op_valid_q, op_valid_d;
    logic              in_run;
    logic              wr_en;
    logic [7:0]        rd0, rd1, rd2, rd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (load_start) state_d = LOAD;
                     else if (load_done) state_d = RUN;
            RUN:     if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == LOAD);
        in_run     = (state_q == RUN);
        state      = state_q;
    end

    // A restart in the same cycle as a handshake discards that byte.
    assign wr_en = load_valid && load_ready && !load_start;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        overflow_d = overflow_q;
        if (load_start) begin
            wr_ptr_d   = '0;
            prog_len_d = '0;
            overflow_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (prog_len_q != DEPTH) prog_len_d = prog_len_q + 1'b1;
            if (wr_ptr_q == TOP_ADDR) overflow_d = 1'b1;
        end
    end

    always_comb begin
        opbus_d    = in_run ? {rd3, rd2, rd1, rd0} : NOP_WORD;
        op_valid_d = in_run;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
            opbus_q    <= NOP_WORD;
            op_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            overflow_q <= overflow_d;
            opbus_q    <= opbus_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign prog_len = prog_len_q;
    assign overflow = overflow_q;
    assign opbus    = opbus_q;
    assign op_valid = op_valid_q;

    prog_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i    (clk),
        .we_i     (wr_en),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (load_data),
        .raddr0_i (pc),
        .raddr1_i (pc + ADDR_W'(1)),
        .raddr2_i (pc + ADDR_W'(2)),
        .raddr3_i (pc + ADDR_W'(3)),
        .rdata0_o (rd0),
        .rdata1_o (rd1),
        .rdata2_o (rd2),
        .rdata3_o (rd3)
    );

`ifdef PROG_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) checksum_d = 8'h00;
        else if (wr_en) checksum_d = checksum_q + load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - self-checking bench for program_memory against a byte-array reference model
module tb_program_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_done = 1'b0;
    logic [7:0]  load_data = 8'h00;
    logic [7:0]  pc = 8'h00;
    logic        load_ready, op_valid, overflow;
    logic [31:0] opbus;
    logic [8:0]  prog_len;
    logic [1:0]  state;
`ifdef PROG_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int total = 0;
    int bad   = 0;

    byte unsigned ref_mem [256];
    int           ref_cnt = 0;
    int           ref_sum = 0;

    program_memory #(.ADDR_W(8), .NOP_WORD(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_done  (load_done),
        .pc         (pc),
        .opbus      (opbus),
        .op_valid   (op_valid),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .state      (state)
`ifdef PROG_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input int p);
        return {ref_mem[(p + 3) % 256], ref_mem[(p + 2) % 256],
                ref_mem[(p + 1) % 256], ref_mem[p % 256]};
    endfunction

    function automatic logic [31:0] exp_len();
        return (ref_cnt > 256) ? 32'd256 : 32'(ref_cnt);
    endfunction

    function automatic logic [31:0] exp_ovf();
        return (ref_cnt >= 256) ? 32'd1 : 32'd0;
    endfunction

    task automatic begin_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ref_cnt = 0;
        ref_sum = 0;
    endtask

    task automatic end_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            load_data = 8'($urandom);
            tick();
        end
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
        ref_mem[ref_cnt % 256] = b;
        ref_cnt++;
        ref_sum = (ref_sum + int'(b)) % 256;
    endtask

    initial begin
        int n;
        logic [7:0] addr_aa;

        // Reset state
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_opbus", opbus, 32'h0);
        chk("rst_len", 32'(prog_len), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        #20 rst = 1'b1;
        tick();

        // Basic load and fetch
        begin_load();
        chk("load_state", 32'(state), 32'd1);
        chk("load_ready", 32'(load_ready), 32'd1);
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        chk("len8", 32'(prog_len), 32'd8);
        pc = 8'h00;
        end_load();
        chk("run_state", 32'(state), 32'd2);
        chk("run_first_valid", 32'(op_valid), 32'd0);
        chk("run_first_opbus", opbus, 32'h0);
        chk("run_ready", 32'(load_ready), 32'd0);
        tick();
        chk("fetch_pc0_valid", 32'(op_valid), 32'd1);
        chk("fetch_pc0", opbus, 32'h04030201);
        pc = 8'h04;
        tick();
        chk("fetch_pc4", opbus, 32'h08070605);

        // Full 256-byte image with byte == address, then wrap-around fetch
        begin_load();
        chk("restart_len", 32'(prog_len), 32'd0);
        for (int i = 0; i < 255; i++) send(8'(i), 0);
        chk("len255", 32'(prog_len), exp_len());
        chk("ovf255", 32'(overflow), exp_ovf());
        send(8'hFF, 0);
        chk("len256", 32'(prog_len), exp_len());
        chk("ovf256", 32'(overflow), exp_ovf());
        end_load();
        pc = 8'hFE;
        tick();
        tick();
        chk("wrap_fetch", opbus, 32'h0100FFFE);

        // 257 bytes: pointer wraps, length saturates, address 0 overwritten
        begin_load();
        for (int i = 0; i < 256; i++) send(8'($urandom), 0);
        send(8'hC3, 0);
        chk("len257", 32'(prog_len), exp_len());
        chk("ovf257", 32'(overflow), 32'd1);
        end_load();
        pc = 8'h00;
        tick();
        tick();
        chk("addr0_257th", 32'(opbus[7:0]), 32'hC3);
        chk("fetch_after_wrap", opbus, ref_op(0));

        // Randomized loads with gaps, random fetches, stray load_valid in RUN
        for (int r = 0; r < 4; r++) begin
            begin_load();
            n = int'($urandom_range(5, 40));
            for (int i = 0; i < n; i++) send(8'($urandom), 2);
            chk("rand_len", 32'(prog_len), exp_len());
            chk("rand_ovf", 32'(overflow), exp_ovf());
            end_load();
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            tick();
            tick();
            load_valid = 1'b0;
            chk("rand_len_run", 32'(prog_len), exp_len());
            for (int k = 0; k < 6; k++) begin
                pc = 8'($urandom);
                tick();
                chk("rand_valid", 32'(op_valid), 32'd1);
                chk("rand_fetch", opbus, ref_op(int'(pc)));
            end
        end

        // load_valid with load_done in one cycle; load_start beats load_done
        begin_load();
        send(8'($urandom), 0);
        send(8'($urandom), 0);
        addr_aa = 8'(ref_cnt);
        pc = addr_aa;
        load_valid = 1'b1;
        load_done  = 1'b1;
        load_data  = 8'hAA;
        tick();
        load_valid = 1'b0;
        load_done  = 1'b0;
        ref_mem[ref_cnt % 256] = 8'hAA;
        ref_cnt++;
        chk("valid_done_state", 32'(state), 32'd2);
        chk("valid_done_len", 32'(prog_len), 32'd3);
        tick();
        chk("valid_done_byte", 32'(opbus[7:0]), 32'hAA);
        chk("valid_done_fetch", opbus, ref_op(int'(addr_aa)));
        load_start = 1'b1;
        load_done  = 1'b1;
        tick();
        chk("start_done_run", 32'(state), 32'd1);
        chk("start_done_len", 32'(prog_len), 32'd0);
        tick();
        load_start = 1'b0;
        load_done  = 1'b0;
        ref_cnt = 0;
        ref_sum = 0;
        chk("start_done_load", 32'(state), 32'd1);

        // Reset mid-load after 3 of 6 bytes; memory survives
        for (int i = 0; i < 3; i++) send(8'($urandom), 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_ready", 32'(load_ready), 32'd0);
        chk("abort_valid", 32'(op_valid), 32'd0);
        chk("abort_len", 32'(prog_len), 32'd0);
        tick();
        rst = 1'b1;
        ref_cnt = 0;
        begin_load();
        end_load();
        pc = 8'h00;
        tick();
        chk("retained_fetch", opbus, ref_op(0));

        // Reset in RUN clears op_valid without waiting for a clock
        #2 rst = 1'b0;
        #1;
        chk("run_rst_valid", 32'(op_valid), 32'd0);
        chk("run_rst_opbus", opbus, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // IDLE ignores load_done
        end_load();
        chk("idle_done", 32'(state), 32'd0);

`ifdef PROG_CHECKSUM_EN
        begin_load();
        send(8'h80, 0);
        send(8'h90, 0);
        chk("checksum", 32'(checksum), 32'h10);
        for (int i = 0; i < 10; i++) send(8'($urandom), 1);
        chk("checksum_rand", 32'(checksum), 32'(ref_sum));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, instruction word driven whenever no valid fetch exists.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port load_data  input  8  program byte to be written.
REQ-007 SHALL have port load_valid  input  1  load_data is valid this cycle.
REQ-008 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port load_done  input  1  single-cycle end-of-load marker.
REQ-010 SHALL have port pc  input  ADDR_W  byte address of the instruction to fetch, from the instruction counter (step 4).
REQ-011 SHALL have port opbus  output  32  fetched instruction {byte pc+3, pc+2, pc+1, pc}: [7:0] opcode, [15:8] arg1, [23:16] arg2, [31:24] result address.
REQ-012 SHALL have port op_valid  output  1  opbus holds a fetched instruction.
REQ-013 SHALL have port prog_len  output  ADDR_W+1  number of bytes written since the last load_start.
REQ-014 SHALL have port overflow  output  1  sticky flag: a write wrapped the write pointer past the top address.
REQ-015 SHALL have port state  output  2  current FSM state (IDLE=0, LOAD=1, RUN=2).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-017 Transitions SHALL be: IDLE->LOAD on load_start; LOAD->RUN on load_done; RUN->LOAD on load_start; IDLE ignores load_done.
REQ-018 In LOAD, load_start SHALL restart the load: wr_ptr=0, prog_len=0, overflow=0; the state stays LOAD.
REQ-019 load_ready SHALL be 1 exactly when state==LOAD.
REQ-020 A byte SHALL be written at wr_ptr when load_valid and load_ready are both 1; wr_ptr then increments modulo 2**ADDR_W.
REQ-021 A write at wr_ptr==2**ADDR_W-1 SHALL wrap wr_ptr to 0 and set overflow; prog_len SHALL saturate at 2**ADDR_W.
REQ-022 If load_valid and load_done coincide in LOAD, the byte SHALL be written and the state SHALL move to RUN in the same edge.
REQ-023 load_start SHALL have priority over load_done in the same cycle.
REQ-024 In RUN, opbus SHALL register the four bytes at pc..pc+3 (address arithmetic modulo 2**ADDR_W) with 1-cycle latency; op_valid=1 from the second RUN cycle onward.
REQ-025 Outside RUN, opbus SHALL be NOP_WORD and op_valid 0 from the next edge.
REQ-026 Memory contents SHALL be retained across state changes and across reset; they are not cleared.

Reset
REQ-027 While rst=0, the block SHALL be in IDLE with wr_ptr=0, prog_len=0, overflow=0, opbus=NOP_WORD, op_valid=0 and load_ready=0, independent of clk.
REQ-028 A reset mid-load SHALL abort the load; bytes already written SHALL remain in memory.

Configuration
REQ-029 With macro PROG_CHECKSUM_EN defined, the block SHALL add output checksum [7:0], an 8-bit modulo-256 sum of bytes accepted since the last load_start, reset to 0.
REQ-030 Without PROG_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-031 Shared package prog_mem_pkg SHALL hold the state enum (IDLE/LOAD/RUN encodings) and the NOP_WORD default constant.
REQ-032 Storage SHALL be sub-module prog_ram: 2**ADDR_W x 8, one synchronous write port, four combinational read ports.

Verification
REQ-033 Reset, then load_start, 8 bytes 0x01..0x08, load_done, pc=0 -> opbus=32'h04030201 and op_valid=1 on the second RUN cycle; pc=4 -> 32'h08070605 one cycle later.
REQ-034 Load 256 bytes plus 1 more byte -> overflow=1, prog_len=256, and address 0 holds the 257th byte.
REQ-035 RUN with pc=8'hFE after loading bytes i=address -> opbus=32'h0100FFFE (wrap-around).
REQ-036 load_valid and load_done in the same cycle with data 0xAA -> byte stored, state=RUN next edge; load_start+load_done together -> state=LOAD, prog_len=0.
REQ-037 Assert rst=0 after 3 of 6 bytes are accepted -> immediate IDLE, op_valid=0; reload without rewriting -> the earlier bytes are still readable.
REQ-038 With PROG_CHECKSUM_EN, load 0x80,0x90 -> checksum=0x10.
